// File: rtl/lsic_pkg.sv
// Shared definitions for the opcode loader/fetch slice.
`default_nettype none

package lsic_pkg;

  localparam int OPCODE_W         = 8;
  localparam int MAX_ADDR_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_writer.sv
// Sequential opcode loader: streams valid/ready opcodes into consecutive sram
// addresses from 0, bounded by MAX_ADDR words per session.
`default_nettype none

module mem_writer
  import lsic_pkg::*;
#(
  parameter int MAX_ADDR = MAX_ADDR_DEFAULT,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [OPCODE_W-1:0] in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [OPCODE_W-1:0] mem_wdata,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [OPCODE_W-1:0] wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                xfer;

  // in_ready is a pure decode of state_q, so the handshake never sees an input path.
  assign xfer = in_valid && (state_q == ST_WRITE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Abort wins over completion: a session ended by abort never pulses done.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (xfer && (addr_q == LAST_ADDR)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    count_d    = count_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    we_d       = xfer;
    if ((state_q == ST_IDLE) && start) begin
      addr_d  = '0;
      count_d = '0;
    end
    if (xfer) begin
      addr_d     = addr_q + ONE;
      count_d    = count_q + ONE;
      mem_addr_d = addr_q;
      wdata_d    = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      count_q    <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b0;
      end
      ST_WRITE: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign mem_we    = we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: doc/mem_writer.md
# mem_writer

Sequential opcode loader for the team's `sram`. It accepts a stream of 8-bit opcodes over a valid/ready handshake and writes them to consecutive addresses, starting at 0. Each session is bounded by `MAX_ADDR` words, and a one-cycle `done` pulse marks its end. It sits between the program source (host/UART/test harness) and the `sram` write port. It fills the same memory image that the opcode fetch path later reads.

## Interface
- `MAX_ADDR`, 8: number of opcode slots per session; legal range 1 .. 2^`ADDR_W`-1.
- `ADDR_W`, 8: width of the address and count.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low; asserting it forces the reset state immediately.
- `start`  in  1  begins a session; honoured only in IDLE.
- `abort`  in  1  ends a session early without `done`; honoured only in WRITE.
- `in_valid`  in  1  upstream has an opcode on `in_data`.
- `in_data`  in  8  opcode.
- `in_ready`  out  1  block can accept an opcode this cycle.
- `mem_we`  out  1  sram write strobe, one cycle per word.
- `mem_addr`  out  `ADDR_W`  sram write address.
- `mem_wdata`  out  8  sram write data.
- `busy`  out  1  high in WRITE and DONE.
- `done`  out  1  one-cycle pulse after the last slot is written.
- `count`  out  `ADDR_W`  opcodes accepted in the current/last session.

## Operation
- States: IDLE, WRITE, DONE.
- Reset values: all outputs 0, state IDLE, internal address 0.
- IDLE:
  - `in_ready`=0.
  - `start`=1 moves to WRITE and clears the address and `count` to 0.
  - `abort` is ignored.
- WRITE:
  - `in_ready`=1 unconditionally. It is a registered state decode, with no combinational path from any input.
  - A transfer occurs when `in_valid` && `in_ready`.
  - On each transfer, `in_data` and the current address are registered onto `mem_wdata`/`mem_addr`, and `mem_we` is asserted for exactly the next cycle.
  - On each transfer, the address and `count` increment by 1.
- Transfer at address `MAX_ADDR`-1:
  - The next state is DONE.
  - `in_ready` drops in the following cycle.
- DONE:
  - Lasts exactly one cycle, with `done`=1.
  - This cycle coincides with `mem_we` for the last word.
  - The next state is IDLE.
  - `start` is ignored.
- `abort` in WRITE:
  - The next state is IDLE, with no `done`.
  - A transfer in the same cycle is still accepted and written, because upstream saw `in_ready`=1.
  - `count` keeps its value, reflecting the words actually written.
- `start` in WRITE or DONE is ignored; it does not restart the session.
- `count` holds its value in IDLE until the next `start`.
- Address arithmetic is unsigned `ADDR_W`-bit. The address never exceeds `MAX_ADDR`, so no wrap occurs.
- When `mem_we`=0, `mem_addr`/`mem_wdata` hold their last values.
- Reset mid-session returns to IDLE at once. Any pending `mem_we` is dropped.

## Timing
- Latency: a transfer in cycle N gives `mem_we`=1 in cycle N+1, with that word's address and data.
- Throughput: one word per cycle while `in_valid` is held high.
- Minimum session length: `start` (cycle 0), then WRITE from cycle 1. With back-to-back valid data, the last transfer is in cycle `MAX_ADDR`, and `done` and the last `mem_we` fall in cycle `MAX_ADDR`+1.
- `in_valid` with `in_ready`=0 is not a transfer. `in_data` is not required to be held stable.

## Structure
- Shared package `lsic_pkg`:
  - state enum (IDLE/WRITE/DONE);
  - opcode width constant (8);
  - default `MAX_ADDR`.
  - The fetch side reuses the opcode width and `MAX_ADDR`.
- No sub-module: the FSM, address counter and write-register stage fit in one module.
- The `sram` is instantiated by the parent, not inside `mem_writer`.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0. Release → IDLE, `in_ready`=0.
- Full session: `start`, then 8 back-to-back opcodes 0xA0..0xA7 → `mem_we` cycles 2..9 with addresses 0..7 and matching data. `done`=1 only in cycle 9. `count`=8. `in_ready`=0 from cycle 9.
- Gapped input: `in_valid` toggling 1/0 → writes only on accepted beats, addresses still contiguous 0..7, `done` after the 8th write.
- Abort: `start`, 3 transfers, then `abort` together with a 4th transfer (0x55) → 4 writes (the last is 0x55 at address 3), no `done`, `count`=4, back in IDLE.
- Ignored controls: `start` pulsed during WRITE and DONE → no address reset. `abort` in IDLE → no effect. A new `start` afterwards → `count` clears and writes restart at address 0.
- Async reset mid-session after 5 transfers → outputs 0 immediately (not at the next edge). Any pending write is dropped.
